// File: rtl/max_pool_window_gen.sv
// Raster-stream to WIN_SIZE x WIN_SIZE window generator for the max-pooling core.
// Optional feature: define MAX_POOL_WIN_SOF_EN to let din_sof re-anchor the frame at (0,0).
module max_pool_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 3,
    parameter int STRIDE     = WIN_SIZE,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 din_vld,
    input  logic signed [DATA_WIDTH-1:0]                         din,
    input  logic                                                 din_sof,
    output logic                                                 win_vld,
    output logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win,
    output logic                                                 frame_done
);

    localparam int X_W  = $clog2(IMG_WIDTH);
    localparam int Y_W  = $clog2(IMG_HEIGHT);
    localparam int PH_W = $clog2(WIN_SIZE);

    localparam logic [X_W-1:0]  X_LAST  = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(IMG_HEIGHT - 1);
    localparam logic [PH_W-1:0] PH_INIT = PH_W'(WIN_SIZE - 1);
    localparam logic [PH_W-1:0] PH_STEP = PH_W'(STRIDE - 1);

    logic [X_W-1:0]  r_x,   w_x;
    logic [Y_W-1:0]  r_y,   w_y;
    logic [PH_W-1:0] r_xph, w_xph;
    logic [PH_W-1:0] r_yph, w_yph;

    logic                                                 r_win_vld;
    logic                                                 r_frame_done;
    logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] r_win_out;
    logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] r_win;
    logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] w_win_nxt;
    logic signed [DATA_WIDTH-1:0] r_lb [WIN_SIZE-1][IMG_WIDTH];

    logic w_row_end;
    logic w_frame_end;
    logic w_emit;

    // Phase counters reach zero exactly on the emitting columns/rows, so the
    // x/y >= WIN_SIZE-1 bound is implied by their initial value.
`ifdef MAX_POOL_WIN_SOF_EN
    logic w_sof;
    assign w_sof = din_vld & din_sof;

    always_comb begin
        w_x   = r_x;
        w_y   = r_y;
        w_xph = r_xph;
        w_yph = r_yph;
        if (w_sof) begin
            w_x   = '0;
            w_y   = '0;
            w_xph = PH_INIT;
            w_yph = PH_INIT;
        end
    end
`else
    logic w_unused_sof;
    assign w_unused_sof = din_sof;

    always_comb begin
        w_x   = r_x;
        w_y   = r_y;
        w_xph = r_xph;
        w_yph = r_yph;
    end
`endif

    assign w_row_end   = (w_x == X_LAST);
    assign w_frame_end = w_row_end && (w_y == Y_LAST);
    assign w_emit      = din_vld && (w_xph == '0) && (w_yph == '0);

    // New column enters on the right: oldest line buffer feeds the top row.
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE - 1; c++) begin
                w_win_nxt[r][c] = r_win[r][c+1];
            end
        end
        for (int r = 0; r < WIN_SIZE - 1; r++) begin
            w_win_nxt[r][WIN_SIZE-1] = r_lb[WIN_SIZE-2-r][w_x];
        end
        w_win_nxt[WIN_SIZE-1][WIN_SIZE-1] = din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_xph        <= PH_INIT;
            r_yph        <= PH_INIT;
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_out    <= '0;
        end else begin
            r_win_vld    <= w_emit;
            r_frame_done <= din_vld && w_frame_end;
            if (w_emit) begin
                r_win_out <= w_win_nxt;
            end
            if (din_vld) begin
                if (w_row_end) begin
                    r_x   <= '0;
                    r_xph <= PH_INIT;
                    if (w_y == Y_LAST) begin
                        r_y   <= '0;
                        r_yph <= PH_INIT;
                    end else begin
                        r_y   <= w_y + 1'b1;
                        r_yph <= (w_yph == '0) ? PH_STEP : w_yph - 1'b1;
                    end
                end else begin
                    r_x   <= w_x + 1'b1;
                    r_xph <= (w_xph == '0) ? PH_STEP : w_xph - 1'b1;
                end
            end
        end
    end

    // Line buffers and the shift window are never cleared; stale contents are
    // always shifted out before the emit condition can select them.
    always_ff @(posedge clk) begin
        if (din_vld) begin
            r_lb[0][w_x] <= din;
            for (int k = 1; k < WIN_SIZE - 1; k++) begin
                r_lb[k][w_x] <= r_lb[k-1][w_x];
            end
            r_win <= w_win_nxt;
        end
    end

    assign win_vld    = r_win_vld;
    assign win        = r_win_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_max_pool_window_gen.sv
// Directed bench for max_pool_window_gen: 6x6 image, 3x3 windows, stride 3 (and a stride-1 twin).
module tb_max_pool_window_gen;

    localparam int DW = 8;
    localparam int WS = 3;
    localparam int IW = 6;
    localparam int IH = 6;
`ifdef MAX_POOL_WIN_SOF_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    typedef logic signed [WS-1:0][WS-1:0][DW-1:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 din_vld;
    logic                 din_sof;
    logic signed [DW-1:0] din;
    logic                 win_vld,  frame_done;
    logic                 win_vld1, frame_done1;
    win_t                 win, win1;

    max_pool_window_gen #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .STRIDE(3),
                          .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .din_sof(din_sof),
        .win_vld(win_vld), .win(win), .frame_done(frame_done));

    max_pool_window_gen #(.DATA_WIDTH(DW), .WIN_SIZE(WS), .STRIDE(1),
                          .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut1 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .din_sof(din_sof),
        .win_vld(win_vld1), .win(win1), .frame_done(frame_done1));

    int   vec  = 0;
    int   miss = 0;
    int   pix_idx;
    logic mon_v;
    int   mon_p;

    win_t cap_win[$];
    int   cap_pix[$];
    bit   cap_fd[$];
    win_t cap1_win[$];
    int   nfd, nfd_alone;

    // Each strobe is tagged with the pixel accepted on the edge just before it.
    always @(posedge clk) begin
        mon_v = din_vld;
        mon_p = pix_idx;
        #1;
        if (win_vld) begin
            cap_win.push_back(win);
            cap_pix.push_back(mon_v ? mon_p : -1);
            cap_fd.push_back(frame_done);
        end
        if (frame_done) begin
            nfd++;
            if (!win_vld) nfd_alone++;
        end
        if (win_vld1) cap1_win.push_back(win1);
    end

    function automatic win_t mk(input int tl, input int off);
        win_t w;
        for (int r = 0; r < WS; r++)
            for (int c = 0; c < WS; c++)
                w[r][c] = 8'(off + tl + IW * r + c);
        return w;
    endfunction

    task automatic clear_caps();
        cap_win.delete(); cap_pix.delete(); cap_fd.delete(); cap1_win.delete();
        nfd = 0; nfd_alone = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_vld = 1'b0; din_sof = 1'b0; pix_idx = -1;
        end
    endtask

    task automatic send(input int idx, input int val, input logic sof, input int gap);
        @(negedge clk);
        din = 8'(val); din_vld = 1'b1; din_sof = sof; pix_idx = idx;
        if (gap > 0) idle(gap);
    endtask

    task automatic send_frame(input int off, input int gap);
        for (int p = 0; p < IW * IH; p++) send(p, off + p, 1'b0, gap);
        idle(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; din_vld = 1'b0; din_sof = 1'b0; din = '0; pix_idx = -1;
        repeat (3) @(negedge clk);
        vec++; if (win_vld !== 1'b0) begin miss++; $display("FAIL reset_win_vld got=%b want=0", win_vld); end
        vec++; if (frame_done !== 1'b0) begin miss++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        vec++; if (win !== '0) begin miss++; $display("FAIL reset_win got=%h want=0", win); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_continuous();
        int exp_pix[4] = '{14, 17, 32, 35};
        int tl[4]      = '{0, 3, 18, 21};
        clear_caps();
        send_frame(0, 0);
        vec++; if (cap_win.size() !== 4) begin miss++; $display("FAIL cont_count got=%0d want=4", cap_win.size()); end
        for (int i = 0; i < 4 && i < cap_win.size(); i++) begin
            vec++; if (cap_pix[i] !== exp_pix[i]) begin miss++; $display("FAIL cont_pix[%0d] got=%0d want=%0d", i, cap_pix[i], exp_pix[i]); end
            vec++; if (cap_win[i] !== mk(tl[i], 0)) begin miss++; $display("FAIL cont_win[%0d] got=%h want=%h", i, cap_win[i], mk(tl[i], 0)); end
            vec++; if (cap_fd[i] !== (i == 3)) begin miss++; $display("FAIL cont_fd[%0d] got=%b want=%b", i, cap_fd[i], (i == 3)); end
        end
        vec++; if (nfd !== 1) begin miss++; $display("FAIL cont_nfd got=%0d want=1", nfd); end
        vec++; if (cap1_win.size() !== 16) begin miss++; $display("FAIL s1_count got=%0d want=16", cap1_win.size()); end
        if (cap1_win.size() >= 16) begin
            vec++; if (cap1_win[1] !== mk(1, 0)) begin miss++; $display("FAIL s1_win1 got=%h want=%h", cap1_win[1], mk(1, 0)); end
            vec++; if (cap1_win[15] !== mk(21, 0)) begin miss++; $display("FAIL s1_win15 got=%h want=%h", cap1_win[15], mk(21, 0)); end
        end
    endtask

    task automatic test_gapped();
        int exp_pix[4] = '{14, 17, 32, 35};
        int tl[4]      = '{0, 3, 18, 21};
        clear_caps();
        send_frame(0, 2);
        vec++; if (cap_win.size() !== 4) begin miss++; $display("FAIL gap_count got=%0d want=4", cap_win.size()); end
        for (int i = 0; i < 4 && i < cap_win.size(); i++) begin
            vec++; if (cap_pix[i] !== exp_pix[i]) begin miss++; $display("FAIL gap_pix[%0d] got=%0d want=%0d", i, cap_pix[i], exp_pix[i]); end
            vec++; if (cap_win[i] !== mk(tl[i], 0)) begin miss++; $display("FAIL gap_win[%0d] got=%h want=%h", i, cap_win[i], mk(tl[i], 0)); end
        end
        vec++; if (nfd !== 1 || nfd_alone !== 0) begin miss++; $display("FAIL gap_nfd got=%0d/%0d want=1/0", nfd, nfd_alone); end
    endtask

    task automatic test_back_to_back();
        int exp_pix[8] = '{14, 17, 32, 35, 50, 53, 68, 71};
        int tl[4]      = '{0, 3, 18, 21};
        clear_caps();
        for (int p = 0; p < IW * IH; p++) send(p, p, 1'b0, 0);
        for (int p = 0; p < IW * IH; p++) send(IW * IH + p, 64 + p, 1'b0, 0);
        idle(4);
        vec++; if (cap_win.size() !== 8) begin miss++; $display("FAIL b2b_count got=%0d want=8", cap_win.size()); end
        for (int i = 0; i < 8 && i < cap_win.size(); i++) begin
            vec++; if (cap_pix[i] !== exp_pix[i]) begin miss++; $display("FAIL b2b_pix[%0d] got=%0d want=%0d", i, cap_pix[i], exp_pix[i]); end
            vec++; if (cap_win[i] !== mk(tl[i % 4], (i < 4) ? 0 : 64)) begin miss++; $display("FAIL b2b_win[%0d] got=%h want=%h", i, cap_win[i], mk(tl[i % 4], (i < 4) ? 0 : 64)); end
        end
        vec++; if (nfd !== 2) begin miss++; $display("FAIL b2b_nfd got=%0d want=2", nfd); end
    endtask

    task automatic test_reset_mid();
        int tl[4] = '{0, 3, 18, 21};
        clear_caps();
        for (int p = 0; p <= 20; p++) send(p, p, 1'b0, 0);
        @(negedge clk);
        din_vld = 1'b0; pix_idx = -1;
        vec++; if (win !== mk(3, 0)) begin miss++; $display("FAIL mid_hold got=%h want=%h", win, mk(3, 0)); end
        reset = 1'b1;
        #1;
        vec++; if (win_vld !== 1'b0 || frame_done !== 1'b0) begin miss++; $display("FAIL mid_rst_ctl got=%b%b want=00", win_vld, frame_done); end
        vec++; if (win !== '0) begin miss++; $display("FAIL mid_rst_win got=%h want=0", win); end
        @(negedge clk);
        reset = 1'b0;
        clear_caps();
        send_frame(0, 0);
        vec++; if (cap_win.size() !== 4) begin miss++; $display("FAIL mid_count got=%0d want=4", cap_win.size()); end
        for (int i = 0; i < 4 && i < cap_win.size(); i++) begin
            vec++; if (cap_win[i] !== mk(tl[i], 0)) begin miss++; $display("FAIL mid_win[%0d] got=%h want=%h", i, cap_win[i], mk(tl[i], 0)); end
        end
        vec++; if (nfd !== 1) begin miss++; $display("FAIL mid_nfd got=%0d want=1", nfd); end
    endtask

    task automatic test_sof();
        int   tl[4]      = '{0, 3, 18, 21};
        int   pix_sof[4] = '{14, 17, 32, 35};
        int   pix_cnt[4] = '{4, 7, 22, 25};
        win_t ew;
        int   g;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_caps();
        for (int p = 0; p < 10; p++) send(100 + p, p, 1'b0, 0);
        for (int p = 0; p < IW * IH; p++) send(p, p, (p == 0), 0);
        idle(4);
        vec++; if (cap_win.size() !== 4) begin miss++; $display("FAIL sof_count got=%0d want=4", cap_win.size()); end
        for (int i = 0; i < 4 && i < cap_win.size(); i++) begin
            for (int r = 0; r < WS; r++)
                for (int c = 0; c < WS; c++) begin
                    g = tl[i] + IW * r + c;
                    ew[r][c] = 8'((SOF_EN || g < 10) ? g : g - 10);
                end
            vec++; if (cap_pix[i] !== (SOF_EN ? pix_sof[i] : pix_cnt[i])) begin miss++; $display("FAIL sof_pix[%0d] got=%0d want=%0d", i, cap_pix[i], SOF_EN ? pix_sof[i] : pix_cnt[i]); end
            vec++; if (cap_win[i] !== ew) begin miss++; $display("FAIL sof_win[%0d] got=%h want=%h", i, cap_win[i], ew); end
            vec++; if (cap_fd[i] !== (i == 3)) begin miss++; $display("FAIL sof_fd[%0d] got=%b want=%b", i, cap_fd[i], (i == 3)); end
        end
        vec++; if (nfd !== 1) begin miss++; $display("FAIL sof_nfd got=%0d want=1", nfd); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_sof();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
